// File: rtl/seg7_pkg.sv
// seg7 scan driver shared constants: hex segment patterns and config checks.
// Patterns are {g,f,e,d,c,b,a}, active-high.
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam int DIGITS_MIN = 1;
  localparam int DIGITS_MAX = 8;

  function automatic bit digits_ok(input int n);
    return (n >= DIGITS_MIN) && (n <= DIGITS_MAX);
  endfunction

endpackage

// File: rtl/seg7_hex_lut.sv
// Combinational hex nibble to 7-segment pattern decoder.
// Pure lookup, no state.
module seg7_hex_lut
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with frame-synchronous update.
// Optional digit blinking is built when SEG7_BLINK_EN is defined.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lzb_en,
`ifdef SEG7_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic [IW-1:0] LAST    = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] DIV_MAX = CW'(CLK_DIV - 1);

  if (!digits_ok(NUM_DIGITS)) begin : g_bad_digits
    $error("seg7_scan_driver: NUM_DIGITS out of range");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("seg7_scan_driver: CLK_DIV must be at least 1");
  end

  logic [CW-1:0]         pre_cnt;
  logic                  tick;
  logic                  fb;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         idx_nxt;
  logic [VW-1:0]         sh_val;
  logic [VW-1:0]         act_val;
  logic [VW-1:0]         cur_val;
  logic [NUM_DIGITS-1:0] sh_dp;
  logic [NUM_DIGITS-1:0] act_dp;
  logic [NUM_DIGITS-1:0] cur_dp;
  logic [NUM_DIGITS-1:0] blank;
  logic                  run;
  logic [3:0]            nib;
  logic                  dp_bit;
  logic                  blk;
  logic [6:0]            lut_seg;
  logic                  hide;
  logic [6:0]            seg_d;
  logic                  dp_d;
  logic [NUM_DIGITS-1:0] an_d;

  assign tick    = (pre_cnt == DIV_MAX);
  assign fb      = tick && (idx == LAST);
  assign idx_nxt = (idx == LAST) ? '0 : idx + 1'b1;

  // Digit 0 of a new frame is decoded from the data being promoted.
  assign cur_val = fb ? sh_val : act_val;
  assign cur_dp  = fb ? sh_dp  : act_dp;

  always_comb begin
    run   = lzb_en;
    blank = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      run      = run & (cur_val[4*k +: 4] == 4'h0);
      blank[k] = run;
    end
  end

  always_comb begin
    nib    = '0;
    dp_bit = 1'b0;
    blk    = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_nxt == IW'(k)) begin
        nib    = cur_val[4*k +: 4];
        dp_bit = cur_dp[k];
        blk    = blank[k];
      end
    end
  end

  seg7_hex_lut u_lut (
    .nibble (nib),
    .seg    (lut_seg)
  );

`ifdef SEG7_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FR_MAX = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0]         fr_cnt;
  logic                  phase;
  logic                  phase_nxt;
  logic [NUM_DIGITS-1:0] sh_mask;
  logic [NUM_DIGITS-1:0] act_mask;
  logic [NUM_DIGITS-1:0] cur_mask;
  logic                  mask_bit;

  // The new frame must already use the phase it will run under.
  assign phase_nxt = (fb && fr_cnt == FR_MAX) ? ~phase : phase;
  assign cur_mask  = fb ? sh_mask : act_mask;

  always_comb begin
    mask_bit = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_nxt == IW'(k)) mask_bit = cur_mask[k];
    end
  end

  assign hide = phase_nxt & mask_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      fr_cnt   <= '0;
      phase    <= 1'b0;
      sh_mask  <= '0;
      act_mask <= '0;
    end else begin
      if (load) sh_mask <= blink_mask;
      if (fb) begin
        act_mask <= sh_mask;
        fr_cnt   <= (fr_cnt == FR_MAX) ? '0 : fr_cnt + 1'b1;
      end
      phase <= phase_nxt;
    end
  end
`else
  logic unused_blink;
  assign unused_blink = (BLINK_FRAMES > 0);
  assign hide = 1'b0;
`endif

  always_comb begin
    seg_d = lut_seg;
    dp_d  = dp_bit;
    an_d  = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_nxt == IW'(k)) an_d[k] = 1'b1;
    end
    if (blk) seg_d = SEG_BLANK;
    if (hide) begin
      seg_d = SEG_BLANK;
      dp_d  = 1'b0;
      an_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt     <= '0;
      idx         <= LAST;
      sh_val      <= '0;
      sh_dp       <= '0;
      act_val     <= '0;
      act_dp      <= '0;
      seg         <= SEG_BLANK;
      dp          <= 1'b0;
      an          <= '0;
      frame_start <= 1'b0;
    end else begin
      pre_cnt     <= tick ? '0 : pre_cnt + 1'b1;
      frame_start <= fb;
      if (load) begin
        sh_val <= value;
        sh_dp  <= dp_in;
      end
      if (fb) begin
        act_val <= sh_val;
        act_dp  <= sh_dp;
      end
      if (tick) begin
        idx <= idx_nxt;
        seg <= seg_d;
        dp  <= dp_d;
        an  <= an_d;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (4 digits, tick every 4 clocks).
// Blink sequence is included when SEG7_BLINK_EN is defined.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        lzb_en = 1'b0;
`ifdef SEG7_BLINK_EN
  logic [3:0]  blink_mask = '0;
`endif
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_start;

  int nvec = 0;
  int nfail = 0;

  logic [3:0] h_an;
  logic [6:0] h_seg;
  logic       h_dp;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS   (4),
    .CLK_DIV      (4),
    .BLINK_FRAMES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .value       (value),
    .dp_in       (dp_in),
    .lzb_en      (lzb_en),
`ifdef SEG7_BLINK_EN
    .blink_mask  (blink_mask),
`endif
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_start (frame_start)
  );

  typedef struct {
    logic [15:0]     value;
    logic [3:0]      dp_in;
    logic            lzb;
    logic [3:0][6:0] segs;
  } vec_t;

  vec_t vecs [8];

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [3:0] e_an,
                     input logic [6:0] e_seg, input logic e_dp,
                     input logic e_fs);
    nvec++;
    if (an !== e_an || seg !== e_seg || dp !== e_dp ||
        frame_start !== e_fs) begin
      nfail++;
      $display("FAIL %s: got an=%b seg=%h dp=%b fs=%b, want an=%b seg=%h dp=%b fs=%b",
               nm, an, seg, dp, frame_start, e_an, e_seg, e_dp, e_fs);
    end
  endtask

  task automatic tk(input int n, input string nm, input logic [3:0] e_an,
                    input logic [6:0] e_seg, input logic e_dp,
                    input logic e_fs);
    for (int i = 1; i < n; i++) begin
      adv(1);
      chk({nm, "_hold"}, h_an, h_seg, h_dp, 1'b0);
    end
    adv(1);
    chk(nm, e_an, e_seg, e_dp, e_fs);
    h_an  = e_an;
    h_seg = e_seg;
    h_dp  = e_dp;
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
    load  = 1'b1;
    adv(1);
    load  = 1'b0;
  endtask

  initial begin
    vecs[0] = '{16'h1234, 4'b0000, 1'b0, {7'h06, 7'h5B, 7'h4F, 7'h66}};
    vecs[1] = '{16'hABCD, 4'b0101, 1'b0, {7'h77, 7'h7C, 7'h39, 7'h5E}};
    vecs[2] = '{16'h0050, 4'b0000, 1'b1, {7'h00, 7'h00, 7'h6D, 7'h3F}};
    vecs[3] = '{16'h0000, 4'b1111, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F}};
    vecs[4] = '{16'h0000, 4'b0000, 1'b0, {7'h3F, 7'h3F, 7'h3F, 7'h3F}};
    vecs[5] = '{16'h0F00, 4'b0010, 1'b1, {7'h00, 7'h71, 7'h3F, 7'h3F}};
    vecs[6] = '{16'h89E7, 4'b1000, 1'b0, {7'h7F, 7'h6F, 7'h79, 7'h07}};
    vecs[7] = '{16'h0006, 4'b0000, 1'b1, {7'h00, 7'h00, 7'h00, 7'h7D}};

    rst = 1'b1;
    adv(3);
    chk("reset", 4'b0000, 7'h00, 1'b0, 1'b0);
    h_an  = '0;
    h_seg = '0;
    h_dp  = 1'b0;
    rst = 1'b0;

    // Each vector: load just after the last digit, then check a full frame.
    for (int i = 0; i < 8; i++) begin
      lzb_en = vecs[i].lzb;
      do_load(vecs[i].value, vecs[i].dp_in);
      chk($sformatf("v%0d_ld_hold", i), h_an, h_seg, h_dp, 1'b0);
      for (int k = 0; k < 4; k++) begin
        tk((k == 0) ? 3 : 4, $sformatf("v%0d_d%0d", i, k),
           4'(1 << k), vecs[i].segs[k], vecs[i].dp_in[k], k == 0);
      end
    end

    // Load in mid-frame: rest of the frame keeps the old data.
    lzb_en = 1'b0;
    do_load(16'h1234, 4'b0000);
    tk(3, "mid_d0", 4'b0001, 7'h66, 1'b0, 1'b1);
    tk(4, "mid_d1", 4'b0010, 7'h4F, 1'b0, 1'b0);
    do_load(16'hABCD, 4'b0000);
    tk(3, "mid_old_d2", 4'b0100, 7'h5B, 1'b0, 1'b0);
    tk(4, "mid_old_d3", 4'b1000, 7'h06, 1'b0, 1'b0);
    tk(4, "mid_new_d0", 4'b0001, 7'h5E, 1'b0, 1'b1);
    tk(4, "mid_new_d1", 4'b0010, 7'h39, 1'b0, 1'b0);
    tk(4, "mid_new_d2", 4'b0100, 7'h7C, 1'b0, 1'b0);
    tk(4, "mid_new_d3", 4'b1000, 7'h77, 1'b0, 1'b0);

    // Load on the frame-boundary edge itself.
    for (int i = 0; i < 3; i++) begin
      adv(1);
      chk("bnd_pre_hold", h_an, h_seg, h_dp, 1'b0);
    end
    value = 16'h5678;
    dp_in = 4'b0000;
    load  = 1'b1;
    adv(1);
    load  = 1'b0;
    chk("bnd_d0_old", 4'b0001, 7'h5E, 1'b0, 1'b1);
    h_an  = 4'b0001;
    h_seg = 7'h5E;
    h_dp  = 1'b0;
    tk(4, "bnd_d1_old", 4'b0010, 7'h39, 1'b0, 1'b0);
    tk(4, "bnd_d2_old", 4'b0100, 7'h7C, 1'b0, 1'b0);
    tk(4, "bnd_d3_old", 4'b1000, 7'h77, 1'b0, 1'b0);
    tk(4, "bnd_d0_new", 4'b0001, 7'h7F, 1'b0, 1'b1);
    tk(4, "bnd_d1_new", 4'b0010, 7'h07, 1'b0, 1'b0);
    tk(4, "bnd_d2_new", 4'b0100, 7'h7D, 1'b0, 1'b0);

    // Reset in mid-frame clears everything including the shadow.
    rst = 1'b1;
    adv(1);
    chk("rst_mid", 4'b0000, 7'h00, 1'b0, 1'b0);
    h_an  = '0;
    h_seg = '0;
    h_dp  = 1'b0;
    rst = 1'b0;
    tk(4, "rst_first_d0", 4'b0001, 7'h3F, 1'b0, 1'b1);
    tk(4, "rst_first_d1", 4'b0010, 7'h3F, 1'b0, 1'b0);

`ifdef SEG7_BLINK_EN
    // Frame 1 is running with phase 0; phase flips on frames 2 and 4.
    blink_mask = 4'b0001;
    do_load(16'h1234, 4'b0000);
    tk(3, "blk_f1_d2", 4'b0100, 7'h3F, 1'b0, 1'b0);
    tk(4, "blk_f1_d3", 4'b1000, 7'h3F, 1'b0, 1'b0);
    for (int f = 2; f <= 5; f++) begin
      if (f == 2 || f == 3)
        tk(4, $sformatf("blk_f%0d_d0", f), 4'b0000, 7'h00, 1'b0, 1'b1);
      else
        tk(4, $sformatf("blk_f%0d_d0", f), 4'b0001, 7'h66, 1'b0, 1'b1);
      tk(4, $sformatf("blk_f%0d_d1", f), 4'b0010, 7'h4F, 1'b0, 1'b0);
      tk(4, $sformatf("blk_f%0d_d2", f), 4'b0100, 7'h5B, 1'b0, 1'b0);
      tk(4, $sformatf("blk_f%0d_d3", f), 4'b1000, 7'h06, 1'b0, 1'b0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
